ks_add_sched: RTL
=================

KS_ADD_SCHED -- requirements
Module: ks_add_sched

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width; 16 is the only supported value.
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester operand valid.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  operand accepted this cycle when high with valid.
REQ-006 SHALL have ports: req0_a, req0_b / req1_a, req1_b  input  16  operands.
REQ-007 SHALL have ports: req0_cin / req1_cin  input  1  carry-in, present only with KS_SCHED_CIN_EN.
REQ-008 SHALL have ports: rsp0_valid / rsp1_valid  output  1  result valid for that requester.
REQ-009 SHALL have ports: rsp0_ready / rsp1_ready  input  1  requester accepts result.
REQ-010 SHALL have ports: rsp0_sum / rsp1_sum  output  16 and rsp0_cout / rsp1_cout  output  1  result.
REQ-011 SHALL have ports: inflight  output  3  count of valid pipeline stages, 0..5.

Function
REQ-012 SHALL share one 5-register-stage Kogge-Stone adder between the two requesters: S0 holds bitwise P=a^b, G=a&b; S1..S4 each apply one prefix level at distance 1, 2, 4, 8 (gray cell where the partner index is below 0 after the level, black cell otherwise, pass-through for bits below the distance).
REQ-013 SHALL compute sum[i]=P[i]^C[i-1] with C[-1]=cin, and cout=C[15], combinationally from S4; each stage carries a 1-bit requester tag and a valid bit.
REQ-014 SHALL define advance = !S4.valid || rspT_ready, T = S4 tag; on advance every stage shifts forward by one; otherwise all stages hold.
REQ-015 SHALL drive rspX_valid = S4.valid && (S4.tag==X); sum/cout SHALL remain stable while valid is held without ready.
REQ-016 SHALL arbitrate round-robin: only one valid -> that requester; both valid -> the requester not granted last; last-grant pointer updates only on an accepted transfer.
REQ-017 SHALL drive reqX_ready = advance && grant==X; ready MAY depend combinationally on both req valids and the S4 rsp_ready, never on its own requester's data.
REQ-018 SHALL insert a bubble (S0.valid=0) on any advance with no accepted request.
REQ-019 SHALL give latency: operand accepted at edge T appears at rsp after edge T+4 when no stall; throughput one result per cycle.
REQ-020 SHALL keep a request's tag, operands and carry-in bound together; results return in acceptance order.
REQ-021 SHALL update inflight each edge to the number of valid stages after the shift; simultaneous accept and retire leave it unchanged.

Reset
REQ-022 SHALL, on rst high, clear all stage valids, set last-grant to requester 1 (requester 0 wins first tie), force inflight=0, rspX_valid=0, reqX_ready=0, rspX_sum=0, rspX_cout=0 asynchronously.
REQ-023 SHALL discard all in-flight operations on reset mid-operation; no result for them is ever produced.
REQ-024 SHALL resume accepting on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, with KS_SCHED_CIN_EN defined, expose req0_cin/req1_cin and fold cin into bit 0: G[0]=a0&b0 | (a0^b0)&cin.
REQ-026 SHALL, without KS_SCHED_CIN_EN, omit the cin ports and use cin=0 throughout.

Verification
REQ-027 SHALL cover single op: req0 a=0x00FF b=0x0001 (cin 0), rsp0_ready=1 -> rsp0_valid 4 edges after accept, sum=0x0100, cout=0.
REQ-028 SHALL cover carry chain: a=0xFFFF b=0x0001 -> sum=0x0000 cout=1; with KS_SCHED_CIN_EN a=0xFFFF b=0x0000 cin=1 -> same result.
REQ-029 SHALL cover contention: both valid every cycle for 8 cycles from reset -> grants alternate 0,1,0,1...; each rsp matches its own operands, inflight reaches 5.
REQ-030 SHALL cover backpressure: rsp1_ready=0 for 6 cycles with S4 holding tag 1 -> both req ready low, rsp1_sum stable, inflight constant; release -> one result per cycle, no loss or duplication.
REQ-031 SHALL cover reset mid-stream: rst asserted with inflight=3 -> all outputs zero immediately, no stale rsp after release.
REQ-032 SHALL cover random: 10k random operands/valids/readies, both requesters -> every result equals (a+b+cin) mod 2^17, in order per requester.

Source files
------------

// File: rtl/ks_add_sched.sv
// ks_add_sched: one 16-bit Kogge-Stone adder, pipelined over five register
// stages and shared between two requesters by a round-robin arbiter.
//
// Build option: define KS_SCHED_CIN_EN to add the req0_cin/req1_cin ports.
// Without it, the carry-in is zero.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   reqX_valid/ready             operand handshake (X = 0, 1)
//   reqX_a, reqX_b               operands
//   reqX_cin                     carry-in (KS_SCHED_CIN_EN only)
//   rspX_valid/ready             result handshake
//   rspX_sum, rspX_cout          result
//   inflight                     number of valid pipeline stages (0..5)
module ks_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
`ifdef KS_SCHED_CIN_EN
  input  logic             req0_cin,
  input  logic             req1_cin,
`endif
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic [2:0]       inflight
);

  localparam int NS = 5;

  typedef enum logic {LAST_0 = 1'b0, LAST_1 = 1'b1} last_t;

  last_t            last_q, last_d;
  logic [NS-1:0]    vld, tag, cin;
  logic [WIDTH-1:0] p0 [NS];    // bitwise propagate, kept for the final sum
  logic [WIDTH-1:0] p  [NS-1];  // group propagate; the last stage never needs it
  logic [WIDTH-1:0] g  [NS];    // group generate
  logic             advance, grant, acc, cin_in;
  logic [WIDTH-1:0] a_in, b_in, p_in, g_in, sum;

  // One prefix level, generate half. Bits below the distance pass through.
  function automatic logic [WIDTH-1:0] lvl_g(input logic [WIDTH-1:0] gi,
                                             input logic [WIDTH-1:0] pi,
                                             input int d);
    logic [WIDTH-1:0] r;
    r = gi;
    for (int i = 0; i < WIDTH; i++)
      if (i >= d) r[i] = gi[i] | (pi[i] & gi[i-d]);
    return r;
  endfunction

  // Propagate half. Once a bit's group reaches bit 0 (i < 2d) it is a gray
  // cell and its propagate is never consumed again, so it just passes through.
  function automatic logic [WIDTH-1:0] lvl_p(input logic [WIDTH-1:0] pi,
                                             input int d);
    logic [WIDTH-1:0] r;
    r = pi;
    for (int i = 0; i < WIDTH; i++)
      if (i >= 2 * d) r[i] = pi[i] & pi[i-d];
    return r;
  endfunction

  always_comb begin
    advance = !vld[NS-1] || (tag[NS-1] ? rsp1_ready : rsp0_ready);
    grant   = 1'b0;
    if (req0_valid && req1_valid) grant = (last_q == LAST_1) ? 1'b0 : 1'b1;
    else if (req1_valid)          grant = 1'b1;
    // Gating with rst keeps both readies low for the whole reset, even though
    // the cleared pipeline would otherwise report advance.
    req0_ready = !rst && advance && !grant;
    req1_ready = !rst && advance && grant;
    acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    last_d     = last_q;
    if (acc) last_d = grant ? LAST_1 : LAST_0;
  end

  always_comb begin
    a_in = grant ? req1_a : req0_a;
    b_in = grant ? req1_b : req0_b;
`ifdef KS_SCHED_CIN_EN
    cin_in = grant ? req1_cin : req0_cin;
`else
    cin_in = 1'b0;
`endif
    p_in    = a_in ^ b_in;
    g_in    = a_in & b_in;
    // The carry-in is folded into bit 0, so every group generate G[i] is
    // already the true carry out of bit i.
    g_in[0] = g_in[0] | (p_in[0] & cin_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= LAST_1;
    else     last_q <= last_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      tag <= '0;
      cin <= '0;
      for (int i = 0; i < NS; i++) begin
        p0[i] <= '0;
        g[i]  <= '0;
      end
      for (int i = 0; i < NS - 1; i++) p[i] <= '0;
    end else if (advance) begin
      vld   <= {vld[NS-2:0], acc};
      tag   <= {tag[NS-2:0], grant};
      cin   <= {cin[NS-2:0], cin_in};
      p0[0] <= p_in;
      p[0]  <= p_in;
      g[0]  <= g_in;
      for (int i = 1; i < NS; i++) begin
        p0[i] <= p0[i-1];
        g[i]  <= lvl_g(g[i-1], p[i-1], 1 << (i - 1));
      end
      for (int i = 1; i < NS - 1; i++) p[i] <= lvl_p(p[i-1], 1 << (i - 1));
    end
  end

  // Reset clears the data registers too, so the sum reads zero during reset.
  assign sum        = p0[NS-1] ^ {g[NS-1][WIDTH-2:0], cin[NS-1]};
  assign rsp0_valid = vld[NS-1] && !tag[NS-1];
  assign rsp1_valid = vld[NS-1] && tag[NS-1];
  assign rsp0_sum   = sum;
  assign rsp1_sum   = sum;
  assign rsp0_cout  = g[NS-1][WIDTH-1];
  assign rsp1_cout  = g[NS-1][WIDTH-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NS; i++) inflight = inflight + {2'b00, vld[i]};
  end

endmodule
